// File: rtl/machine_phase_pkg.sv
// Shared types and parameter checks for the machine-cycle phase generator.
package machine_phase_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_e;

    // Legal when there are at least two phases and the index can name every phase.
    function automatic bit params_ok(input int num_phases, input int ph_w);
        return (num_phases >= 2) && ((64'(1) << ph_w) >= 64'(num_phases));
    endfunction

endpackage

// File: rtl/machine_phase_gen_phase_divider.sv
// Per-phase clock divider: holds the sub-phase count and the divide ratio
// latched at machine-cycle start, and exposes next-cycle decode for output registers.
module phase_divider #(
    parameter int DIV_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_start,
    input  logic             i_en,
    output logic             o_last,
    output logic             o_first_nxt,
    output logic             o_last_nxt
);

    logic [DIV_W-1:0] r_sub;
    logic [DIV_W-1:0] r_div_q;
    logic [DIV_W-1:0] w_sub_nxt;
    logic [DIV_W-1:0] w_div_q_nxt;

    assign o_last = (r_sub == r_div_q);

    always_comb begin
        w_sub_nxt   = r_sub;
        w_div_q_nxt = r_div_q;
        if (i_start) begin
            w_sub_nxt   = '0;
            w_div_q_nxt = i_div;
        end else if (i_en) begin
            w_sub_nxt = o_last ? '0 : r_sub + DIV_W'(1);
        end
    end

    assign o_first_nxt = (w_sub_nxt == '0);
    assign o_last_nxt  = (w_sub_nxt == w_div_q_nxt);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sub   <= '0;
            r_div_q <= '0;
        end else begin
            r_sub   <= w_sub_nxt;
            r_div_q <= w_div_q_nxt;
        end
    end

endmodule

// File: rtl/machine_phase_gen.sv
// N-phase machine-cycle enable generator with run/halt/single-step control.
// Optional breakpoint on cycle count enabled by defining MACHINE_PHASE_BREAK_EN.
module machine_phase_gen
    import machine_phase_pkg::*;
#(
    parameter int DIV_W      = 4,
    parameter int NUM_PHASES = 2,
    parameter int PH_W       = 1,
    parameter int CYC_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DIV_W-1:0]      i_div,
    input  logic                  i_run,
    input  logic                  i_step,
    input  logic                  i_halt_req,
`ifdef MACHINE_PHASE_BREAK_EN
    input  logic [CYC_W-1:0]      i_brk_cyc,
    input  logic                  i_brk_arm,
    input  logic                  i_clr_brk,
    output logic                  o_brk_hit,
`endif
    output logic [NUM_PHASES-1:0] o_ph_stb,
    output logic [PH_W-1:0]       o_ph_idx,
    output logic                  o_cyc_done,
    output logic                  o_m_lvl,
    output logic                  o_busy,
    output logic [CYC_W-1:0]      o_cyc_cnt
);

    localparam bit            P_OK    = params_ok(NUM_PHASES, PH_W);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);
    localparam logic [PH_W-1:0] HALF_PH = PH_W'(NUM_PHASES / 2);

    if (!P_OK) begin : g_bad_params
        $error("machine_phase_gen: NUM_PHASES must be >= 2 and PH_W wide enough");
    end

    state_e           r_state, w_state_nxt;
    logic [PH_W-1:0]  r_ph_idx, w_ph_nxt;
    logic [CYC_W-1:0] r_cyc_cnt;
    logic             r_halt_pend, w_halt_pend_nxt;
    logic             w_start, w_en, w_last, w_first_nxt, w_last_nxt;
    logic             w_cyc_end, w_brk_fire, w_stop;
    logic [NUM_PHASES-1:0] w_stb_nxt;
    logic             w_done_nxt, w_m_lvl_nxt, w_busy_nxt;

    phase_divider #(.DIV_W(DIV_W)) u_div (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_div       (i_div),
        .i_start     (w_start),
        .i_en        (w_en),
        .o_last      (w_last),
        .o_first_nxt (w_first_nxt),
        .o_last_nxt  (w_last_nxt)
    );

    assign w_en      = (r_state != S_IDLE);
    assign w_cyc_end = w_en && w_last && (r_ph_idx == LAST_PH);

`ifdef MACHINE_PHASE_BREAK_EN
    logic r_brk_hit;
    // Compare against the count as it will read once this cycle is credited.
    assign w_brk_fire = w_cyc_end && i_brk_arm && ((r_cyc_cnt + CYC_W'(1)) == i_brk_cyc);
    assign o_brk_hit  = r_brk_hit;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_brk_hit <= 1'b0;
        else          r_brk_hit <= (r_brk_hit && !i_clr_brk) || w_brk_fire;
    end
`else
    assign w_brk_fire = 1'b0;
`endif

    assign w_stop = r_halt_pend || i_halt_req || !i_run || w_brk_fire;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run) begin
                    w_state_nxt = S_RUN;
                    w_start     = 1'b1;
                end else if (i_step) begin
                    w_state_nxt = S_STEP;
                    w_start     = 1'b1;
                end
            end
            S_RUN: begin
                if (w_cyc_end) begin
                    if (w_stop) w_state_nxt = S_IDLE;
                    else        w_start     = 1'b1;
                end
            end
            S_STEP: begin
                if (w_cyc_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ph_nxt = r_ph_idx;
        if (w_start)               w_ph_nxt = '0;
        else if (w_en && w_last)   w_ph_nxt = (r_ph_idx == LAST_PH) ? '0 : r_ph_idx + PH_W'(1);

        w_halt_pend_nxt = (r_state == S_RUN) && !w_cyc_end && (r_halt_pend || i_halt_req);

        // Outputs are decoded from next-cycle state so the registered copies line up with it.
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_stb_nxt   = (w_busy_nxt && w_first_nxt) ? (NUM_PHASES'(1) << w_ph_nxt) : '0;
        w_done_nxt  = w_busy_nxt && w_last_nxt && (w_ph_nxt == LAST_PH);
        w_m_lvl_nxt = w_busy_nxt && (w_ph_nxt < HALF_PH);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ph_idx    <= '0;
            r_cyc_cnt   <= '0;
            r_halt_pend <= 1'b0;
            o_ph_stb    <= '0;
            o_cyc_done  <= 1'b0;
            o_m_lvl     <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            r_ph_idx    <= w_ph_nxt;
            r_halt_pend <= w_halt_pend_nxt;
            if (w_cyc_end) r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
            o_ph_stb    <= w_stb_nxt;
            o_cyc_done  <= w_done_nxt;
            o_m_lvl     <= w_m_lvl_nxt;
            o_busy      <= w_busy_nxt;
        end
    end

    assign o_ph_idx  = r_ph_idx;
    assign o_cyc_cnt = r_cyc_cnt;

endmodule

// File: tb/tb_machine_phase_gen.sv
// Self-checking bench for machine_phase_gen: directed scenarios plus random
// stimulus against a cycle-position reference model.
module tb_machine_phase_gen;

    localparam int DIV_W = 4;
    localparam int NP    = 2;
    localparam int PH_W  = 1;
    localparam int CYC_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DIV_W-1:0] div;
    logic             run, step, halt_req;
    logic [NP-1:0]    ph_stb;
    logic [PH_W-1:0]  ph_idx;
    logic             cyc_done, m_lvl, busy;
    logic [CYC_W-1:0] cyc_cnt;
`ifdef MACHINE_PHASE_BREAK_EN
    logic [CYC_W-1:0] brk_cyc;
    logic             brk_arm, clr_brk, brk_hit;
`endif

    always #5 clk = ~clk;

    machine_phase_gen #(.DIV_W(DIV_W), .NUM_PHASES(NP), .PH_W(PH_W), .CYC_W(CYC_W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_div      (div),
        .i_run      (run),
        .i_step     (step),
        .i_halt_req (halt_req),
`ifdef MACHINE_PHASE_BREAK_EN
        .i_brk_cyc  (brk_cyc),
        .i_brk_arm  (brk_arm),
        .i_clr_brk  (clr_brk),
        .o_brk_hit  (brk_hit),
`endif
        .o_ph_stb   (ph_stb),
        .o_ph_idx   (ph_idx),
        .o_cyc_done (cyc_done),
        .o_m_lvl    (m_lvl),
        .o_busy     (busy),
        .o_cyc_cnt  (cyc_cnt)
    );

    int checks = 0;
    int errors = 0;
    int clk_n  = 0;

    // Reference model: a machine cycle is a position t in [0, (d+1)*NP).
    bit         m_act, m_is_run, m_halt, m_hit;
    int         m_t, m_d;
    logic [CYC_W-1:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s clk=%0d observed=%0h expected=%0h", tag, clk_n, obs, exp);
        end
    endtask

    task automatic model_step();
        bit fire;
        int period;
        fire = 1'b0;
        if (!rst_n) begin
            m_act = 0; m_is_run = 0; m_halt = 0; m_hit = 0; m_t = 0; m_d = 0; m_cnt = '0;
        end else begin
            if (!m_act) begin
                if (run)       begin m_act = 1; m_is_run = 1; m_d = int'(div); m_t = 0; end
                else if (step) begin m_act = 1; m_is_run = 0; m_d = int'(div); m_t = 0; end
            end else begin
                period = (m_d + 1) * NP;
                if (m_is_run && halt_req) m_halt = 1;
                if (m_t == period - 1) begin
                    m_cnt = m_cnt + 1'b1;
`ifdef MACHINE_PHASE_BREAK_EN
                    fire = brk_arm && (m_cnt == brk_cyc);
`endif
                    if (!m_is_run) m_act = 0;
                    else if (m_halt || !run || fire) begin m_act = 0; m_halt = 0; end
                    else begin m_d = int'(div); m_t = 0; end
                end else begin
                    m_t++;
                end
            end
`ifdef MACHINE_PHASE_BREAK_EN
            m_hit = (m_hit && !clr_brk) || fire;
`endif
        end
    endtask

    task automatic compare();
        int ph;
        logic [NP-1:0] e_stb;
        ph    = m_act ? m_t / (m_d + 1) : 0;
        e_stb = (m_act && (m_t % (m_d + 1) == 0)) ? NP'(1 << ph) : '0;
        chk("ph_stb",   32'(ph_stb),   32'(e_stb));
        chk("ph_idx",   32'(ph_idx),   32'(ph));
        chk("cyc_done", 32'(cyc_done), 32'(m_act && (m_t == (m_d + 1) * NP - 1)));
        chk("m_lvl",    32'(m_lvl),    32'(m_act && (ph < NP / 2)));
        chk("busy",     32'(busy),     32'(m_act));
        chk("cyc_cnt",  32'(cyc_cnt),  32'(m_cnt));
`ifdef MACHINE_PHASE_BREAK_EN
        chk("brk_hit",  32'(brk_hit),  32'(m_hit));
`endif
    endtask

    // One system clock: model follows the edge, outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        clk_n++;
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        tick();
        rst_n = 1'b1;
        clk_n = 0;
    endtask

    initial begin
        rst_n = 1'b0; div = '0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
`ifdef MACHINE_PHASE_BREAK_EN
        brk_cyc = '0; brk_arm = 1'b0; clr_brk = 1'b0;
`endif
        m_act = 0; m_is_run = 0; m_halt = 0; m_hit = 0; m_t = 0; m_d = 0; m_cnt = '0;

        // Reset state
        do_reset();
        chk("rst_stb",  32'(ph_stb), 32'(0));
        chk("rst_busy", 32'(busy),   32'(0));
        chk("rst_cnt",  32'(cyc_cnt), 32'(0));

        // Free run, div=2: strobe/done/m_lvl timeline from the raise of run at clk 0
        div = 4'd2; run = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            chk("tl_stb0", 32'(ph_stb[0]), 32'(k == 1 || k == 7 || k == 13));
            chk("tl_stb1", 32'(ph_stb[1]), 32'(k == 4 || k == 10));
            chk("tl_done", 32'(cyc_done),  32'(k == 6 || k == 12));
            if (k <= 6) chk("tl_mlvl", 32'(m_lvl), 32'(k <= 3));
        end

        // Single step with div=0; second step while busy is ignored
        do_reset();
        div = 4'd0; step = 1'b1;
        tick(); chk("st_stb_a", 32'(ph_stb), 32'(2'b01));
        tick(); chk("st_stb_b", 32'(ph_stb), 32'(2'b10)); chk("st_done", 32'(cyc_done), 32'(1));
        step = 1'b0;
        tick(); chk("st_busy", 32'(busy), 32'(0)); chk("st_cnt", 32'(cyc_cnt), 32'(1));
        tick(); chk("st_idle", 32'(busy), 32'(0));

        // Halt pulse during phase 0 of a div=1 run: cycle completes then IDLE
        do_reset();
        div = 4'd1; run = 1'b1;
        tick(); halt_req = 1'b1;
        tick(); halt_req = 1'b0;
        tick(); tick(); chk("hl_done", 32'(cyc_done), 32'(1));
        tick(); chk("hl_busy", 32'(busy), 32'(0)); chk("hl_stb", 32'(ph_stb), 32'(0));
        run = 1'b0; tick();

        // div 2 -> 5 mid-cycle: done at clk 6, then a 12-clk cycle ending at clk 18
        do_reset();
        div = 4'd2; run = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 2) div = 4'd5;
            chk("dv_done", 32'(cyc_done), 32'(k == 6 || k == 18));
        end
        run = 1'b0;

        // Reset for one clock mid-phase with run held
        do_reset();
        div = 4'd3; run = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0; tick();
        chk("mr_busy", 32'(busy), 32'(0)); chk("mr_stb", 32'(ph_stb), 32'(0));
        chk("mr_cnt", 32'(cyc_cnt), 32'(0));
        rst_n = 1'b1; tick();
        chk("mr_stb0", 32'(ph_stb), 32'(2'b01)); chk("mr_cnt0", 32'(cyc_cnt), 32'(0));

        // Counter wrap: 16 cycles of div=0 take cyc_cnt 15 -> 0
        do_reset();
        div = 4'd0; run = 1'b1;
        repeat (31) tick();
        chk("wr_15", 32'(cyc_cnt), 32'(15));
        repeat (2) tick();
        chk("wr_0", 32'(cyc_cnt), 32'(0));
        run = 1'b0;

`ifdef MACHINE_PHASE_BREAK_EN
        // Breakpoint at cycle 3 halts the run and stays sticky until cleared
        do_reset();
        div = 4'd0; brk_cyc = 4'd3; brk_arm = 1'b1; run = 1'b1;
        repeat (7) tick();
        run = 1'b0; brk_arm = 1'b0;
        chk("bk_busy", 32'(busy), 32'(0)); chk("bk_hit", 32'(brk_hit), 32'(1));
        chk("bk_cnt", 32'(cyc_cnt), 32'(3));
        tick(); chk("bk_sticky", 32'(brk_hit), 32'(1));
        clr_brk = 1'b1; tick(); clr_brk = 1'b0;
        chk("bk_clr", 32'(brk_hit), 32'(0));
`endif

        // Randomised control traffic against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 19) == 0) run = ~run;
            step     = ($urandom_range(0, 7) == 0);
            halt_req = ($urandom_range(0, 15) == 0);
            div      = DIV_W'($urandom_range(0, 3));
`ifdef MACHINE_PHASE_BREAK_EN
            brk_arm  = ($urandom_range(0, 3) == 0);
            brk_cyc  = CYC_W'($urandom);
            clr_brk  = ($urandom_range(0, 15) == 0);
`endif
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
